// File: rtl/rr_grant_encoder_pkg.sv
// Shared definitions for the round-robin grant encoder: bit-order constants,
// converter modes and the per-thread / per-tile index types.
package rr_grant_encoder_pkg;

    localparam logic [31:0] DIR_LSB0 = "LSB0";
    localparam logic [31:0] DIR_MSB0 = "MSB0";

    typedef enum logic {
        CONV_ENCODE,
        CONV_DECODE
    } conv_mode_e;

    localparam int THREAD_COUNT = 4;
    localparam int TILE_COUNT   = 16;

    typedef logic [$clog2(THREAD_COUNT)-1:0] thread_id_t;
    typedef logic [TILE_COUNT-1:0]           tile_mask_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Physical bit that carries logical index i under the chosen bit order.
    function automatic int bit_pos(input int i, input int n, input logic [31:0] dir);
        return (dir == DIR_MSB0) ? (n - 1 - i) : i;
    endfunction

endpackage

// File: rtl/rr_grant_encoder_oh_idx_conv.sv
// One-hot <-> binary index converter; MODE selects encode or decode.
// Encoding ORs together the indices of all set bits, so multi-hot input is defined.
module oh_idx_conv
    import rr_grant_encoder_pkg::*;
#(
    parameter conv_mode_e  MODE      = CONV_ENCODE,
    parameter int          SIGNALS   = 4,
    parameter int          IDX_WIDTH = 2,
    parameter logic [31:0] DIRECTION = DIR_LSB0,
    parameter int          IN_WIDTH  = (MODE == CONV_ENCODE) ? SIGNALS : IDX_WIDTH,
    parameter int          OUT_WIDTH = (MODE == CONV_ENCODE) ? IDX_WIDTH : SIGNALS
) (
    input  logic [IN_WIDTH-1:0]  in_vec,
    output logic [OUT_WIDTH-1:0] out_vec
);

    generate
        if (MODE == CONV_ENCODE) begin : g_encode
            always_comb begin
                out_vec = '0;
                for (int i = 0; i < SIGNALS; i++) begin
                    if (in_vec[bit_pos(i, SIGNALS, DIRECTION)]) begin
                        out_vec = out_vec | OUT_WIDTH'(i);
                    end
                end
            end
        end else begin : g_decode
            // Out-of-range indices match no entry and leave the output all-zero.
            always_comb begin
                out_vec = '0;
                for (int i = 0; i < SIGNALS; i++) begin
                    if (32'(in_vec) == i) begin
                        out_vec[bit_pos(i, SIGNALS, DIRECTION)] = 1'b1;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter with binary grant index and a stand-alone index decoder.
// Only state is the one-hot priority pointer; all outputs are combinational.
module rr_grant_encoder
    import rr_grant_encoder_pkg::*;
#(
    parameter int          SIZE          = 4,
    parameter int          INDEX_WIDTH   = idx_width(SIZE),
    parameter logic [31:0] DIRECTION     = DIR_LSB0,
    parameter int          DEC_SIGNALS   = 16,
    parameter int          DEC_IDX_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [SIZE-1:0]          requests,
    output logic [SIZE-1:0]          decision_oh,
    output logic [INDEX_WIDTH-1:0]   decision_idx,
    output logic                     decision_valid,
    input  logic [DEC_IDX_WIDTH-1:0] dec_index,
    output logic [DEC_SIGNALS-1:0]   dec_one_hot
);

    logic [SIZE-1:0]   priority_oh;
    logic [SIZE-1:0]   priority_next;
    logic [SIZE-1:0]   grant;
    logic [2*SIZE-1:0] req_dbl;
    logic [2*SIZE-1:0] gnt_dbl;

    // Subtracting the priority bit from the doubled request vector isolates the
    // first request at or above the pointer; the upper copy provides the wrap.
    assign req_dbl = {requests, requests};
    assign gnt_dbl = req_dbl & ~(req_dbl - {{SIZE{1'b0}}, priority_oh});
    assign grant   = gnt_dbl[SIZE-1:0] | gnt_dbl[2*SIZE-1:SIZE];

    generate
        if (SIZE == 1) begin : g_single
            assign priority_next = 1'b1;
        end else begin : g_rotate
            assign priority_next = {grant[SIZE-2:0], grant[SIZE-1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            priority_oh <= SIZE'(1);
        end else if (en && (|requests)) begin
            priority_oh <= priority_next;
        end
    end

    assign decision_oh    = grant;
    assign decision_valid = |requests;

    oh_idx_conv #(
        .MODE      (CONV_ENCODE),
        .SIGNALS   (SIZE),
        .IDX_WIDTH (INDEX_WIDTH),
        .DIRECTION (DIRECTION)
    ) u_grant_enc (
        .in_vec  (grant),
        .out_vec (decision_idx)
    );

    oh_idx_conv #(
        .MODE      (CONV_DECODE),
        .SIGNALS   (DEC_SIGNALS),
        .IDX_WIDTH (DEC_IDX_WIDTH),
        .DIRECTION (DIRECTION)
    ) u_index_dec (
        .in_vec  (dec_index),
        .out_vec (dec_one_hot)
    );

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Scoreboard bench for rr_grant_encoder: a reference priority model queues the
// expected outputs per driven cycle, which are popped and compared after settling.
module tb_rr_grant_encoder;
    import rr_grant_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  requests;
    logic [3:0]  dec_index;

    logic [3:0]  l_oh, m_oh;
    logic [1:0]  l_idx, m_idx;
    logic        l_valid, m_valid;
    logic [15:0] l_dec, m_dec;

    logic [3:0]  dec10_in;
    logic [9:0]  dec10_out;
    logic [3:0]  enc_in;
    logic [1:0]  enc_out;

    always #5 clk = ~clk;

    rr_grant_encoder #(
        .SIZE(4), .DIRECTION(DIR_LSB0), .DEC_SIGNALS(16), .DEC_IDX_WIDTH(4)
    ) u_dut_lsb (
        .clk(clk), .reset(reset), .en(en), .requests(requests),
        .decision_oh(l_oh), .decision_idx(l_idx), .decision_valid(l_valid),
        .dec_index(dec_index), .dec_one_hot(l_dec)
    );

    rr_grant_encoder #(
        .SIZE(4), .DIRECTION(DIR_MSB0), .DEC_SIGNALS(16), .DEC_IDX_WIDTH(4)
    ) u_dut_msb (
        .clk(clk), .reset(reset), .en(en), .requests(requests),
        .decision_oh(m_oh), .decision_idx(m_idx), .decision_valid(m_valid),
        .dec_index(dec_index), .dec_one_hot(m_dec)
    );

    oh_idx_conv #(.MODE(CONV_DECODE), .SIGNALS(10), .IDX_WIDTH(4)) u_dec10 (
        .in_vec(dec10_in), .out_vec(dec10_out)
    );

    oh_idx_conv #(.MODE(CONV_ENCODE), .SIGNALS(4), .IDX_WIDTH(2)) u_enc4 (
        .in_vec(enc_in), .out_vec(enc_out)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  model_prio = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       return 32'(l_oh);
            1:       return 32'(l_idx);
            2:       return 32'(l_valid);
            3:       return 32'(m_oh);
            4:       return 32'(m_idx);
            5:       return 32'(m_valid);
            6:       return 32'(l_dec);
            7:       return 32'(m_dec);
            8:       return 32'(dec10_out);
            default: return 32'(enc_out);
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, observe(e.sel), e.exp);
        end
    endtask

    // One clock cycle: drive, check outputs for the current priority, advance model.
    task automatic step(input logic [3:0] req, input logic en_v, input logic rst_v,
                        input string tag);
        int w;
        @(negedge clk);
        requests = req;
        en       = en_v;
        reset    = rst_v;
        w = -1;
        for (int k = 0; k < 4; k++) begin
            if (w < 0 && req[(model_prio + k) % 4]) w = (model_prio + k) % 4;
        end
        expect_val({tag, ".oh"},      0, (w < 0) ? 0 : (1 << w));
        expect_val({tag, ".idx"},     1, (w < 0) ? 0 : w);
        expect_val({tag, ".valid"},   2, (req != 0) ? 1 : 0);
        expect_val({tag, ".msb_oh"},  3, (w < 0) ? 0 : (1 << w));
        expect_val({tag, ".msb_idx"}, 4, (w < 0) ? 0 : (3 - w));
        expect_val({tag, ".msb_vld"}, 5, (req != 0) ? 1 : 0);
        #1;
        drain();
        if (rst_v)                  model_prio = 0;
        else if (en_v && w >= 0)    model_prio = (w + 1) % 4;
        @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] enc_tab [5];
        int         e_exp;

        reset     = 1'b1;
        en        = 1'b0;
        requests  = '0;
        dec_index = '0;
        dec10_in  = '0;
        enc_in    = '0;
        repeat (2) @(posedge clk);

        step(4'b1111, 1'b0, 1'b0, "reset_state");
        repeat (5) step(4'b1111, 1'b1, 1'b0, "rotate_all");

        step(4'b0010, 1'b1, 1'b0, "to_bit2");
        step(4'b0011, 1'b1, 1'b0, "wrap0");
        step(4'b0011, 1'b1, 1'b0, "wrap1");

        step(4'b0000, 1'b0, 1'b1, "t3_reset");
        repeat (3) step(4'b0100, 1'b0, 1'b0, "hold_en0");
        step(4'b1111, 1'b0, 1'b0, "after_hold");

        step(4'b0000, 1'b1, 1'b0, "no_req");
        step(4'b1000, 1'b1, 1'b0, "only3");

        step(4'b0100, 1'b1, 1'b0, "to_bit3");
        step(4'b1111, 1'b1, 1'b1, "reset_mid");
        step(4'b1111, 1'b1, 1'b0, "post_reset");

        repeat (6) step(4'b1011, 1'b1, 1'b0, "fair");

        for (int n = 0; n < 40; n++) begin
            step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0, "random");
        end

        for (int i = 0; i < 16; i++) begin
            dec_index = 4'(i);
            dec10_in  = 4'(i);
            expect_val($sformatf("dec_lsb[%0d]", i), 6, 32'(1) << i);
            expect_val($sformatf("dec_msb[%0d]", i), 7, 32'(1) << (15 - i));
            expect_val($sformatf("dec10[%0d]", i),   8, (i < 10) ? (32'(1) << i) : 32'(0));
            #1;
            drain();
        end

        enc_tab = '{4'b0110, 4'b0000, 4'b1001, 4'b0100, 4'b0011};
        for (int t = 0; t < 5; t++) begin
            enc_in = enc_tab[t];
            e_exp  = 0;
            for (int b = 0; b < 4; b++) if (enc_tab[t][b]) e_exp = e_exp | b;
            expect_val($sformatf("enc[%b]", enc_tab[t]), 9, e_exp);
            #1;
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
